trig_pulse_tx: RTL

- Board-side transmitter for the coax trigger link; the trigger board stretches pulses arriving on this link and forms coincidences from them.
- Converts per-channel trigger requests into clean, fixed-width coax pulses, with a programmable holdoff between pulses.
- Provides a calibration force-fire input and per-channel sent-pulse counters for monitoring.
- Sits between the local discriminator/trigger logic and the coax output pins, in the clk_adc domain.

---
 rtl/trig_pulse_tx_pkg.sv | 22 ++
 rtl/trig_pulse_tx_if.sv | 37 +++
 rtl/trig_pulse_tx_chan.sv | 107 ++++++++++
 rtl/trig_pulse_tx.sv | 111 +++++++++++
 4 files changed

// File: rtl/trig_pulse_tx_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// coax trigger transmitter.
package trig_tx_pkg;

  localparam int TRIG_TW  = 8;
  localparam int TRIG_CW  = 32;
  localparam int TRIG_NCH = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PULSE,
    TX_HOLDOFF
  } tx_state_t;

  // Width-generic: callers widen to 64 bits and cast the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_v;
    max_v = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= max_v) ? max_v : value + 64'd1;
  endfunction

endpackage

// File: rtl/trig_pulse_tx_if.sv
// Control, coax and monitoring bundle of trig_pulse_tx. drop_out exists only
// when TRIG_TX_DROP_COUNT_EN is defined.
interface trig_pulse_tx_if #(
  parameter int NCH = trig_tx_pkg::TRIG_NCH,
  parameter int TW  = trig_tx_pkg::TRIG_TW,
  parameter int CW  = trig_tx_pkg::TRIG_CW
);
  logic [NCH-1:0] trig_req;
  logic [NCH-1:0] chan_en;
  logic           force_pulse;
  logic [TW-1:0]  pulse_width;
  logic [TW-1:0]  holdoff;
  logic [NCH-1:0] coax_out;
  logic [NCH-1:0] busy;
  logic [3:0]     cnt_sel;
  logic           cnt_clear;
  logic [CW-1:0]  cnt_out;
`ifdef TRIG_TX_DROP_COUNT_EN
  logic [CW-1:0]  drop_out;
`endif

  modport master (
    output trig_req, chan_en, force_pulse, pulse_width, holdoff, cnt_sel, cnt_clear,
`ifdef TRIG_TX_DROP_COUNT_EN
    input  drop_out,
`endif
    input  coax_out, busy, cnt_out
  );

  modport slave (
    input  trig_req, chan_en, force_pulse, pulse_width, holdoff, cnt_sel, cnt_clear,
`ifdef TRIG_TX_DROP_COUNT_EN
    output drop_out,
`endif
    output coax_out, busy, cnt_out
  );
endinterface

// File: rtl/trig_pulse_tx_chan.sv
// One coax channel: IDLE/PULSE/HOLDOFF sequencer with registered outputs and
// saturating sent (and, with TRIG_TX_DROP_COUNT_EN, dropped) fire counters.
module trig_tx_chan
  import trig_tx_pkg::*;
#(
  parameter int TW = TRIG_TW,
  parameter int CW = TRIG_CW
) (
  input  logic          clk_adc,
  input  logic          nrst,
  input  logic          fire_i,
  input  logic [TW-1:0] pulse_width_i,
  input  logic [TW-1:0] holdoff_i,
  input  logic          cnt_clear_i,
  output logic          coax_o,
  output logic          busy_o,
  output logic [CW-1:0] cnt_o
`ifdef TRIG_TX_DROP_COUNT_EN
  ,
  output logic [CW-1:0] drop_o
`endif
);

  tx_state_t     state_q;
  logic [TW-1:0] tmr_q;
  logic          coax_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  assign accept = fire_i && (state_q == TX_IDLE);
  assign cnt_d  = CW'(sat_inc(64'(cnt_q), CW));

  // Outputs are registered from the state, so the pin follows the state by one cycle.
  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      state_q <= TX_IDLE;
      tmr_q   <= '0;
      coax_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      coax_q <= (state_q == TX_PULSE);
      busy_q <= (state_q != TX_IDLE);
      case (state_q)
        TX_IDLE: begin
          if (fire_i) begin
            tmr_q   <= (pulse_width_i == '0) ? TW'(1) : pulse_width_i;
            state_q <= TX_PULSE;
          end
        end
        TX_PULSE: begin
          if (tmr_q <= TW'(1)) begin
            if (holdoff_i == '0) begin
              state_q <= TX_IDLE;
            end else begin
              tmr_q   <= holdoff_i;
              state_q <= TX_HOLDOFF;
            end
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        TX_HOLDOFF: begin
          if (tmr_q <= TW'(1)) begin
            state_q <= TX_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_adc) begin
    if (!nrst || cnt_clear_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_d;
    end
  end

  assign coax_o = coax_q;
  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

`ifdef TRIG_TX_DROP_COUNT_EN
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;
  logic          drop;

  assign drop   = fire_i && (state_q != TX_IDLE);
  assign drop_d = CW'(sat_inc(64'(drop_q), CW));

  always_ff @(posedge clk_adc) begin
    if (!nrst || cnt_clear_i) begin
      drop_q <= '0;
    end else if (drop) begin
      drop_q <= drop_d;
    end
  end

  assign drop_o = drop_q;
`endif

endmodule

// File: rtl/trig_pulse_tx.sv
// Coax trigger transmitter: input registers, rising-edge/force fire detect,
// NCH channel sequencers and registered counter readout (TRIG_TX_DROP_COUNT_EN adds drop counters).
module trig_pulse_tx
  import trig_tx_pkg::*;
#(
  parameter int NCH = TRIG_NCH,
  parameter int TW  = TRIG_TW,
  parameter int CW  = TRIG_CW
) (
  input  logic            clk_adc,
  input  logic            nrst,
  trig_pulse_tx_if.slave  bus
);

  logic [NCH-1:0] req_q;
  logic [NCH-1:0] req_dly_q;
  logic           force_q;
  logic [TW-1:0]  pw_q;
  logic [TW-1:0]  ho_q;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] coax;
  logic [NCH-1:0] busy;
  logic [CW-1:0]  cnt_arr [16];
  logic [CW-1:0]  cnt_out_q;

  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      req_q     <= '0;
      req_dly_q <= '0;
      force_q   <= 1'b0;
      pw_q      <= '0;
      ho_q      <= '0;
    end else begin
      req_q     <= bus.trig_req;
      req_dly_q <= req_q;
      force_q   <= bus.force_pulse;
      pw_q      <= bus.pulse_width;
      ho_q      <= bus.holdoff;
    end
  end

  // A coincident edge and force strobe collapse into a single fire.
  assign fire = bus.chan_en & ((req_q & ~req_dly_q) | {NCH{force_q}});

`ifdef TRIG_TX_DROP_COUNT_EN
  logic [CW-1:0] drop_arr [16];
  logic [CW-1:0] drop_out_q;
`endif

  // Unused select slots above NCH read back as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ch
      if (gi < NCH) begin : g_live
        logic [CW-1:0] cnt_w;
`ifdef TRIG_TX_DROP_COUNT_EN
        logic [CW-1:0] drop_w;
`endif
        trig_tx_chan #(.TW(TW), .CW(CW)) u_chan (
          .clk_adc       (clk_adc),
          .nrst          (nrst),
          .fire_i        (fire[gi]),
          .pulse_width_i (pw_q),
          .holdoff_i     (ho_q),
          .cnt_clear_i   (bus.cnt_clear),
          .coax_o        (coax[gi]),
          .busy_o        (busy[gi]),
          .cnt_o         (cnt_w)
`ifdef TRIG_TX_DROP_COUNT_EN
          ,
          .drop_o        (drop_w)
`endif
        );
        assign cnt_arr[gi] = cnt_w;
`ifdef TRIG_TX_DROP_COUNT_EN
        assign drop_arr[gi] = drop_w;
`endif
      end else begin : g_pad
        assign cnt_arr[gi] = '0;
`ifdef TRIG_TX_DROP_COUNT_EN
        assign drop_arr[gi] = '0;
`endif
      end
    end
  endgenerate

  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      cnt_out_q <= '0;
    end else begin
      cnt_out_q <= cnt_arr[bus.cnt_sel];
    end
  end

`ifdef TRIG_TX_DROP_COUNT_EN
  always_ff @(posedge clk_adc) begin
    if (!nrst) begin
      drop_out_q <= '0;
    end else begin
      drop_out_q <= drop_arr[bus.cnt_sel];
    end
  end

  assign bus.drop_out = drop_out_q;
`endif

  assign bus.coax_out = coax;
  assign bus.busy     = busy;
  assign bus.cnt_out  = cnt_out_q;

endmodule
